// File: rtl/crc_pkg.sv
// Shared CRC-16-CCITT definitions: widths, polynomial, seed, FSM states and the byte-wide update.
package crc_pkg;

    localparam int unsigned CRC_WIDTH = 16;
    localparam int unsigned CNT_WIDTH = 11;

    localparam logic [CRC_WIDTH-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_WIDTH-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        CHECK  = 3'd2,
        RESULT = 3'd3
    } state_e;

    // Fold one byte into the CRC, MSB first, no reflection.
    function automatic logic [CRC_WIDTH-1:0] crc16_byte(
        input logic [CRC_WIDTH-1:0] crc,
        input logic [7:0]           data,
        input logic [CRC_WIDTH-1:0] poly = CRC_POLY
    );
        logic [CRC_WIDTH-1:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[CRC_WIDTH-1] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_calc_check.sv
// Accumulates a CRC-16 over a block of bytes, then compares it and the byte count
// against the expected values and holds the verdict until the next start.
module crc_calc_check
    import crc_pkg::CRC_WIDTH;
    import crc_pkg::CNT_WIDTH;
    import crc_pkg::state_e;
    import crc_pkg::IDLE;
    import crc_pkg::ACCUM;
    import crc_pkg::CHECK;
    import crc_pkg::RESULT;
    import crc_pkg::crc16_byte;
#(
    parameter int unsigned          N_BYTES  = 1024,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY = crc_pkg::CRC_POLY,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT = crc_pkg::CRC_INIT
) (
    input  logic                 clk50m,
    input  logic                 rst_n,
    input  logic                 crc_start,
    input  logic                 crc_en,
    input  logic [7:0]           data_in,
    input  logic                 crc_rdy,
    input  logic [CRC_WIDTH-1:0] crc_expected,
    output logic [CRC_WIDTH-1:0] crc_value,
    output logic [CNT_WIDTH-1:0] byte_cnt,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 crc_pass,
    output logic                 crc_fail,
    output logic                 len_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_TARGET = CNT_WIDTH'(N_BYTES);

    state_e               state_q, state_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 len_err_q, len_err_d;
    logic                 crc_ok, len_ok;

    assign crc_ok = (crc_q == crc_expected);
    assign len_ok = (cnt_q == CNT_TARGET);

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= CRC_INIT;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            len_err_q <= len_err_d;
        end
    end

    // Start overrides everything (including an abort mid-run); otherwise per-state behaviour.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        len_err_d = len_err_q;

        if (crc_start) begin
            state_d   = ACCUM;
            crc_d     = crc_en ? crc16_byte(CRC_INIT, data_in, CRC_POLY) : CRC_INIT;
            cnt_d     = crc_en ? CNT_WIDTH'(1) : '0;
            valid_d   = 1'b0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            len_err_d = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (crc_en) begin
                        crc_d = crc16_byte(crc_q, data_in, CRC_POLY);
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    end
                    if (crc_rdy) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    valid_d   = 1'b1;
                    pass_d    = crc_ok && len_ok;
                    fail_d    = !(crc_ok && len_ok);
                    len_err_d = !len_ok;
                    state_d   = RESULT;
                end
                IDLE, RESULT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == ACCUM) || (state_d == CHECK);
    end

    assign crc_value    = crc_q;
    assign byte_cnt     = cnt_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign crc_pass     = pass_q;
    assign crc_fail     = fail_q;
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_crc_calc_check.sv
// Directed bench for crc_calc_check using the "123456789" CRC-16/CCITT-FALSE check value 16'h29B1.
module tb_crc_calc_check;

    logic        clk50m = 1'b0;
    logic        rst_n;
    logic        crc_start;
    logic        crc_en;
    logic [7:0]  data_in;
    logic        crc_rdy;
    logic [15:0] crc_expected;
    logic [15:0] crc_value;
    logic [10:0] byte_cnt;
    logic        busy;
    logic        result_valid;
    logic        crc_pass;
    logic        crc_fail;
    logic        len_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc_calc_check #(.N_BYTES(9)) dut (
        .clk50m       (clk50m),
        .rst_n        (rst_n),
        .crc_start    (crc_start),
        .crc_en       (crc_en),
        .data_in      (data_in),
        .crc_rdy      (crc_rdy),
        .crc_expected (crc_expected),
        .crc_value    (crc_value),
        .byte_cnt     (byte_cnt),
        .busy         (busy),
        .result_valid (result_valid),
        .crc_pass     (crc_pass),
        .crc_fail     (crc_fail),
        .len_err      (len_err)
    );

    always #10 clk50m = ~clk50m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to 1 ns after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic pulse_start();
        crc_start = 1'b1;
        tick();
        crc_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        crc_en  = 1'b1;
        data_in = b;
        tick();
        crc_en  = 1'b0;
        data_in = 8'h00;
        tick();
        tick();
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(msg[i]);
    endtask

    // Pulses crc_rdy, checks result_valid is still low after the first edge and high after the second.
    task automatic finish_run(input string tag);
        crc_rdy = 1'b1;
        tick();
        crc_rdy = 1'b0;
        check_val({tag, "_valid_t1"}, 32'(result_valid), 32'd0);
        tick();
        check_val({tag, "_valid_t2"}, 32'(result_valid), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b1;
        crc_start    = 1'b0;
        crc_en       = 1'b0;
        data_in      = 8'h00;
        crc_rdy      = 1'b0;
        crc_expected = 16'h29B1;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_crc",   32'(crc_value),    32'hFFFF);
        check_val("rst_cnt",   32'(byte_cnt),     32'd0);
        check_val("rst_busy",  32'(busy),         32'd0);
        check_val("rst_valid", 32'(result_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Stays idle and ignores crc_en without a start.
        send_byte(8'hA5);
        check_val("idle_en_crc", 32'(crc_value), 32'hFFFF);
        check_val("idle_en_cnt", 32'(byte_cnt),  32'd0);
        check_val("idle_busy",   32'(busy),      32'd0);

        // Golden run.
        pulse_start();
        check_val("gold_busy", 32'(busy), 32'd1);
        send_bytes(9);
        check_val("gold_cnt", 32'(byte_cnt), 32'd9);
        finish_run("gold");
        check_val("gold_crc",  32'(crc_value), 32'h29B1);
        check_val("gold_pass", 32'(crc_pass),  32'd1);
        check_val("gold_fail", 32'(crc_fail),  32'd0);
        check_val("gold_len",  32'(len_err),   32'd0);
        check_val("gold_busy_done", 32'(busy), 32'd0);

        // RESULT ignores crc_en and crc_rdy.
        send_byte(8'h55);
        crc_rdy = 1'b1;
        tick();
        crc_rdy = 1'b0;
        tick();
        check_val("hold_crc",   32'(crc_value),    32'h29B1);
        check_val("hold_cnt",   32'(byte_cnt),     32'd9);
        check_val("hold_valid", 32'(result_valid), 32'd1);

        // Mismatch.
        crc_expected = 16'h29B0;
        pulse_start();
        check_val("restart_valid", 32'(result_valid), 32'd0);
        check_val("restart_pass",  32'(crc_pass),     32'd0);
        check_val("restart_crc",   32'(crc_value),    32'hFFFF);
        check_val("restart_cnt",   32'(byte_cnt),     32'd0);
        send_bytes(9);
        finish_run("mism");
        check_val("mism_fail", 32'(crc_fail), 32'd1);
        check_val("mism_pass", 32'(crc_pass), 32'd0);
        check_val("mism_len",  32'(len_err),  32'd0);

        // Length error: only 8 bytes.
        crc_expected = 16'h29B1;
        pulse_start();
        send_bytes(8);
        finish_run("len");
        check_val("len_err",  32'(len_err),  32'd1);
        check_val("len_fail", 32'(crc_fail), 32'd1);
        check_val("len_pass", 32'(crc_pass), 32'd0);

        // Abort after 5 bytes, then a full run.
        pulse_start();
        send_bytes(5);
        check_val("abort_cnt5", 32'(byte_cnt), 32'd5);
        pulse_start();
        check_val("abort_cnt0", 32'(byte_cnt), 32'd0);
        check_val("abort_crc0", 32'(crc_value), 32'hFFFF);
        send_bytes(9);
        finish_run("abort");
        check_val("abort_cnt",  32'(byte_cnt),  32'd9);
        check_val("abort_pass", 32'(crc_pass),  32'd1);

        // Start coinciding with the first byte, last byte coinciding with crc_rdy.
        crc_start = 1'b1;
        crc_en    = 1'b1;
        data_in   = msg[0];
        tick();
        crc_start = 1'b0;
        crc_en    = 1'b0;
        check_val("coin_start_cnt", 32'(byte_cnt), 32'd1);
        tick();
        for (int i = 1; i < 8; i++) send_byte(msg[i]);
        crc_en  = 1'b1;
        data_in = msg[8];
        finish_run("coin");
        crc_en  = 1'b0;
        check_val("coin_crc",  32'(crc_value), 32'h29B1);
        check_val("coin_cnt",  32'(byte_cnt),  32'd9);
        check_val("coin_pass", 32'(crc_pass),  32'd1);

        // Asynchronous reset mid-ACCUM.
        pulse_start();
        send_bytes(4);
        #5 rst_n = 1'b0;
        #1;
        check_val("midrst_crc",   32'(crc_value),    32'hFFFF);
        check_val("midrst_cnt",   32'(byte_cnt),     32'd0);
        check_val("midrst_busy",  32'(busy),         32'd0);
        check_val("midrst_valid", 32'(result_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h31);
        check_val("post_rst_cnt", 32'(byte_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
